// File: rtl/dino_sprite_if.sv
// Scan, game-input, sprite-ROM and VGA signals between the timing logic and the dino renderer.
interface dino_sprite_if #(
   parameter int ADDR_W = 12
);
   logic              pix_en;
   logic [9:0]        h_cnt;
   logic [9:0]        v_cnt;
   logic [9:0]        pos;
   logic              dino_behavior;
   logic [1:0]        game_state;
   logic [ADDR_W-1:0] rom_addr;
   logic [2:0]        rom_sel;
   logic [11:0]       rom_data;
   logic [3:0]        vgaRed;
   logic [3:0]        vgaGreen;
   logic [3:0]        vgaBlue;

   modport master (
      output pix_en, h_cnt, v_cnt, pos, dino_behavior, game_state, rom_data,
      input  rom_addr, rom_sel, vgaRed, vgaGreen, vgaBlue
   );
   modport slave (
      input  pix_en, h_cnt, v_cnt, pos, dino_behavior, game_state, rom_data,
      output rom_addr, rom_sel, vgaRed, vgaGreen, vgaBlue
   );
endinterface

// File: rtl/dino_sprite_engine.sv
// Dino sprite renderer: frame-latched inputs, frame-counted animation and death blink,
// sprite-ROM addressing and colour-keyed output aligned to the ROM latency.
module dino_sprite_engine #(
   parameter int          SPRITE_X     = 80,
   parameter int          GROUND       = 298,
   parameter int          STAND_W      = 44,
   parameter int          STAND_H      = 49,
   parameter int          SIT_W        = 59,
   parameter int          SIT_H        = 30,
   parameter int          ADDR_W       = 12,
   parameter int          ROM_LATENCY  = 1,
   parameter int          ANIM_FRAMES  = 6,
   parameter int          BLINK_FRAMES = 32,
   parameter logic [11:0] KEY_COLOR    = 12'hFFF,
   parameter logic [11:0] BG_COLOR     = 12'hFFF
) (
   input logic          clk,
   input logic          rst,
   dino_sprite_if.slave bus
);
   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_END   = 2'd2;

   localparam logic [2:0] P_STAND = 3'd0;
   localparam logic [2:0] P_RUN_A = 3'd1;
   localparam logic [2:0] P_RUN_B = 3'd2;
   localparam logic [2:0] P_SIT_A = 3'd3;
   localparam logic [2:0] P_SIT_B = 3'd4;
   localparam logic [2:0] P_DEAD  = 3'd5;

   localparam int AW     = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   localparam int BW_RAW = $clog2(BLINK_FRAMES + 1);
   // blink_cnt[3] drives the hide test, so keep at least four bits
   localparam int BW     = (BW_RAW < 4) ? 4 : BW_RAW;

   logic [9:0]          pos_l, pos_e;
   logic                beh_l, beh_e;
   logic [1:0]          state_l, state_e;
   logic [AW-1:0]       anim_cnt, anim_e;
   logic                phase, phase_e;
   logic [BW-1:0]       blink_cnt, blink_e;
   logic                frame_start;

   logic [2:0]          pose;
   logic signed [10:0]  spr_w, spr_h, hs, vs, x_lo, x_hi, y_lo, y_hi, dx, dy;
   logic [21:0]         lin;
   logic                in_box, visible;
   logic [ADDR_W-1:0]   addr_n;

   logic [ADDR_W-1:0]   rom_addr_q;
   logic [2:0]          rom_sel_q;
   logic [ROM_LATENCY:0] vld_pipe;
   logic [11:0]         pix_q;

   // "_e" values are what this strobe renders with: on a frame start they are
   // the freshly latched ones, so the frame-start pixel already sees them.
   always_comb begin
      frame_start = bus.pix_en && (bus.h_cnt == '0) && (bus.v_cnt == '0);
      pos_e   = pos_l;
      beh_e   = beh_l;
      state_e = state_l;
      anim_e  = anim_cnt;
      phase_e = phase;
      blink_e = blink_cnt;
      if (frame_start) begin
         pos_e   = bus.pos;
         beh_e   = bus.dino_behavior;
         state_e = bus.game_state;
         if (state_l == ST_START) begin
            if (anim_cnt == AW'(ANIM_FRAMES - 1)) begin
               anim_e  = '0;
               phase_e = ~phase;
            end else begin
               anim_e = anim_cnt + 1'b1;
            end
         end else begin
            anim_e  = '0;
            phase_e = 1'b0;
         end
         if (bus.game_state == ST_END && state_l != ST_END)
            blink_e = BW'(BLINK_FRAMES);
         else if (bus.game_state == ST_END && blink_cnt != '0)
            blink_e = blink_cnt - 1'b1;
         else if (bus.game_state != ST_END)
            blink_e = '0;
      end
   end

   always_comb begin
      pose = P_STAND;
      case (state_e)
         ST_END:   pose = P_DEAD;
         ST_START: begin
            if (!beh_e)                    pose = phase_e ? P_SIT_B : P_SIT_A;
            else if (pos_e == 10'(GROUND)) pose = phase_e ? P_RUN_B : P_RUN_A;
            else                           pose = P_STAND;
         end
         default:  pose = beh_e ? P_STAND : P_SIT_A;
      endcase
   end

   // Signed 11-bit box test: a sprite poking above the screen clips instead of wrapping.
   always_comb begin
      spr_w   = (pose == P_SIT_A || pose == P_SIT_B) ? 11'(SIT_W) : 11'(STAND_W);
      spr_h   = (pose == P_SIT_A || pose == P_SIT_B) ? 11'(SIT_H) : 11'(STAND_H);
      hs      = $signed({1'b0, bus.h_cnt});
      vs      = $signed({1'b0, bus.v_cnt});
      x_hi    = 11'(SPRITE_X);
      x_lo    = x_hi - spr_w;
      y_hi    = $signed({1'b0, pos_e});
      y_lo    = y_hi - spr_h;
      in_box  = (hs >= x_lo) && (hs < x_hi) && (vs >= y_lo) && (vs < y_hi);
      dx      = hs - x_lo;
      dy      = vs - y_lo;
      lin     = 22'($unsigned(dy)) * 22'($unsigned(spr_w)) + 22'($unsigned(dx));
      addr_n  = in_box ? lin[ADDR_W-1:0] : '0;
      visible = !((blink_e != '0) && blink_e[3]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_l      <= 10'(GROUND);
         beh_l      <= 1'b1;
         state_l    <= ST_INIT;
         anim_cnt   <= '0;
         phase      <= 1'b0;
         blink_cnt  <= '0;
         rom_addr_q <= '0;
         rom_sel_q  <= P_STAND;
         vld_pipe   <= '0;
         pix_q      <= BG_COLOR;
      end else if (bus.pix_en) begin
         pos_l      <= pos_e;
         beh_l      <= beh_e;
         state_l    <= state_e;
         anim_cnt   <= anim_e;
         phase      <= phase_e;
         blink_cnt  <= blink_e;
         rom_addr_q <= addr_n;
         rom_sel_q  <= pose;
         vld_pipe   <= {vld_pipe[ROM_LATENCY-1:0], in_box && visible};
         if (vld_pipe[ROM_LATENCY] && bus.rom_data != KEY_COLOR)
            pix_q <= bus.rom_data;
         else
            pix_q <= BG_COLOR;
      end
   end

   assign bus.rom_addr = rom_addr_q;
   assign bus.rom_sel  = rom_sel_q;
   assign bus.vgaRed   = pix_q[11:8];
   assign bus.vgaGreen = pix_q[7:4];
   assign bus.vgaBlue  = pix_q[3:0];
endmodule

// File: tb/tb_dino_sprite_engine.sv
// Randomized bench for dino_sprite_engine: two instances (ROM latency 1 and 2) share stimulus
// and are scored against a frame-level behavioural model of poses, box, blink and colour key.
module tb_dino_sprite_engine;
   localparam logic [11:0] KEY = 12'hFFF;
   localparam logic [11:0] BG  = 12'hFFF;
   localparam int GROUND = 298;
   localparam int ANIM   = 6;
   localparam int BLINK  = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       pix_en, beh;
   logic [9:0] h_cnt, v_cnt, pos;
   logic [1:0] gs;

   dino_sprite_if #(.ADDR_W(12)) if1 ();
   dino_sprite_if #(.ADDR_W(12)) if2 ();

   assign if1.pix_en = pix_en;  assign if2.pix_en = pix_en;
   assign if1.h_cnt  = h_cnt;   assign if2.h_cnt  = h_cnt;
   assign if1.v_cnt  = v_cnt;   assign if2.v_cnt  = v_cnt;
   assign if1.pos    = pos;     assign if2.pos    = pos;
   assign if1.dino_behavior = beh;  assign if2.dino_behavior = beh;
   assign if1.game_state    = gs;   assign if2.game_state    = gs;

   dino_sprite_engine u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   dino_sprite_engine #(.ROM_LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

   int rom_mode, en_mode;
   int n_checks = 0, n_pass = 0;

   function automatic logic [11:0] rom_f(input logic [2:0] sel, input logic [11:0] addr);
      int a;
      a = int'(addr);
      if (rom_mode == 0) return 12'h000;
      if (a % 7 == 3) return KEY;
      return 12'((a * 37 + int'(sel) * 611) & 'hFFF);
   endfunction

   // Sprite ROMs: one and two pixel strobes of read latency.
   logic [11:0] rom1_q, rom2_a, rom2_q;
   always @(posedge clk) if (pix_en) rom1_q <= rom_f(if1.rom_sel, if1.rom_addr);
   always @(posedge clk) if (pix_en) begin
      rom2_a <= rom_f(if2.rom_sel, if2.rom_addr);
      rom2_q <= rom2_a;
   end
   assign if1.rom_data = rom1_q;
   assign if2.rom_data = rom2_q;

   // Model: latched game inputs plus frame counts since START / since entering END.
   int m_pos, m_state, m_n, m_ef;
   bit m_beh;
   int g_pos, g_gs;
   bit g_beh;
   logic [11:0] q1[$], q2[$];
   logic [11:0] last1, last2, last_addr;
   logic [2:0]  last_sel;

   function automatic logic [11:0] out1();
      return {if1.vgaRed, if1.vgaGreen, if1.vgaBlue};
   endfunction
   function automatic logic [11:0] out2();
      return {if2.vgaRed, if2.vgaGreen, if2.vgaBlue};
   endfunction

   task automatic model_frame();
      int prev;
      prev    = m_state;
      m_pos   = g_pos;
      m_beh   = g_beh;
      m_state = g_gs;
      m_n     = (prev == 1) ? m_n + 1 : 0;
      if (m_state == 2 && prev != 2) m_ef = 0;
      else if (m_state == 2)         m_ef++;
   endtask

   task automatic model_pixel(input int h, input int v, output logic [2:0] sel,
                              output logic [11:0] addr, output logic [11:0] pix);
      int w, ht, x0, y0, blink;
      bit ph, inb, vis;
      logic [11:0] rv;
      ph = ((m_n / ANIM) % 2) == 1;
      if (m_state == 2)      sel = 3'd5;
      else if (m_state == 1) sel = !m_beh ? (ph ? 3'd4 : 3'd3) : (m_pos == GROUND ? (ph ? 3'd2 : 3'd1) : 3'd0);
      else                   sel = m_beh ? 3'd0 : 3'd3;
      w  = (sel == 3 || sel == 4) ? 59 : 44;
      ht = (sel == 3 || sel == 4) ? 30 : 49;
      x0 = 80 - w;
      y0 = m_pos - ht;
      inb  = h >= x0 && h < 80 && v >= y0 && v < m_pos;
      addr = inb ? 12'((v - y0) * w + h - x0) : 12'd0;
      blink = (m_state == 2 && BLINK - m_ef > 0) ? BLINK - m_ef : 0;
      vis  = !(blink != 0 && (blink % 16) >= 8);
      rv   = rom_f(sel, addr);
      pix  = (inb && vis && rv != KEY) ? rv : BG;
   endtask

   task automatic do_reset();
      rst = 1'b1; pix_en = 1'($urandom); h_cnt = '0; v_cnt = '0;
      pos = 10'($urandom); gs = 2'($urandom); beh = 1'($urandom);
      @(posedge clk); #1;
      rst = 1'b0; pix_en = 1'b0;
      m_pos = GROUND; m_beh = 1'b1; m_state = 0; m_n = 0; m_ef = 0;
      q1.delete(); q2.delete();
      repeat (2) q1.push_back(BG);
      repeat (3) q2.push_back(BG);
      last1 = BG; last2 = BG; last_sel = 3'd0; last_addr = 12'd0;
   endtask

   // One pixel strobe, optionally preceded by idle clocks carrying junk inputs.
   task automatic strobe(input int h, input int v);
      int idle;
      logic [2:0] es;
      logic [11:0] ea, ep;
      idle = (en_mode == 0) ? 0 : (en_mode == 1) ? 1 : int'($urandom_range(0, 2));
      for (int i = 0; i < idle; i++) begin
         pix_en = 1'b0;
         h_cnt = $urandom_range(0, 1) ? 10'd0 : 10'($urandom);
         v_cnt = $urandom_range(0, 1) ? 10'd0 : 10'($urandom);
         pos = 10'($urandom); gs = 2'($urandom); beh = 1'($urandom);
         @(posedge clk); #1;
         n_checks++; if (out1() !== last1) $display("FAIL hold_out1: got %h expected %h", out1(), last1); else n_pass++;
         n_checks++; if (out2() !== last2) $display("FAIL hold_out2: got %h expected %h", out2(), last2); else n_pass++;
         n_checks++; if (if1.rom_sel !== last_sel) $display("FAIL hold_sel: got %0d expected %0d", if1.rom_sel, last_sel); else n_pass++;
         n_checks++; if (if1.rom_addr !== last_addr) $display("FAIL hold_addr: got %0d expected %0d", if1.rom_addr, last_addr); else n_pass++;
      end
      pix_en = 1'b1; h_cnt = 10'(h); v_cnt = 10'(v);
      pos = 10'(g_pos); beh = g_beh; gs = 2'(g_gs);
      if (h == 0 && v == 0) model_frame();
      model_pixel(h, v, es, ea, ep);
      @(posedge clk); #1;
      q1.push_back(ep); q2.push_back(ep);
      n_checks++; if (if1.rom_sel !== es) $display("FAIL sel1 h=%0d v=%0d: got %0d expected %0d", h, v, if1.rom_sel, es); else n_pass++;
      n_checks++; if (if1.rom_addr !== ea) $display("FAIL addr1 h=%0d v=%0d: got %0d expected %0d", h, v, if1.rom_addr, ea); else n_pass++;
      n_checks++; if (if2.rom_sel !== es) $display("FAIL sel2 h=%0d v=%0d: got %0d expected %0d", h, v, if2.rom_sel, es); else n_pass++;
      n_checks++; if (if2.rom_addr !== ea) $display("FAIL addr2 h=%0d v=%0d: got %0d expected %0d", h, v, if2.rom_addr, ea); else n_pass++;
      last_sel = es; last_addr = ea;
      if (q1.size() > 2) begin
         last1 = q1.pop_front();
         n_checks++; if (out1() !== last1) $display("FAIL pix1: got %h expected %h", out1(), last1); else n_pass++;
      end
      if (q2.size() > 3) begin
         last2 = q2.pop_front();
         n_checks++; if (out2() !== last2) $display("FAIL pix2: got %h expected %h", out2(), last2); else n_pass++;
      end
   endtask

   task automatic rand_points(input int n);
      int h, v;
      for (int i = 0; i < n; i++) begin
         h = int'($urandom_range(15, 90));
         v = m_pos + 3 - int'($urandom_range(0, 60));
         if (v < 0) v = 0;
         if (v > 1023) v = 1023;
         strobe(h, v);
      end
   endtask

   task automatic test_reset();
      int hl[7] = '{35, 36, 37, 50, 78, 79, 80};
      int vl[5] = '{248, 249, 250, 297, 298};
      rom_mode = 0; en_mode = 0; g_pos = 298; g_beh = 1'b1; g_gs = 0;
      do_reset();
      n_checks++; if (out1() !== BG) $display("FAIL reset_out1: got %h expected %h", out1(), BG); else n_pass++;
      n_checks++; if (out2() !== BG) $display("FAIL reset_out2: got %h expected %h", out2(), BG); else n_pass++;
      n_checks++; if (if1.rom_sel !== 3'd0) $display("FAIL reset_sel: got %0d expected 0", if1.rom_sel); else n_pass++;
      n_checks++; if (if1.rom_addr !== 12'd0) $display("FAIL reset_addr: got %0d expected 0", if1.rom_addr); else n_pass++;
      strobe(0, 0);
      foreach (vl[j]) foreach (hl[i]) strobe(hl[i], vl[j]);
      strobe(37, 250);
      n_checks++; if (if1.rom_addr !== 12'd45) $display("FAIL init_addr: got %0d expected 45", if1.rom_addr); else n_pass++;
      strobe(600, 600); strobe(600, 600);
      n_checks++; if (out1() !== 12'h000) $display("FAIL init_black1: got %h expected 000", out1()); else n_pass++;
      strobe(600, 600);
      n_checks++; if (out2() !== 12'h000) $display("FAIL init_black2: got %h expected 000", out2()); else n_pass++;
      strobe(35, 249); strobe(600, 600); strobe(600, 600);
      n_checks++; if (out1() !== BG) $display("FAIL init_edge_bg: got %h expected %h", out1(), BG); else n_pass++;
   endtask

   task automatic test_run_anim();
      int e;
      rom_mode = 1; en_mode = 1; g_gs = 1; g_beh = 1'b1; g_pos = 298;
      do_reset();
      for (int f = 1; f <= 14; f++) begin
         strobe(0, 0);
         strobe(50, 280);
         e = (((f - 1) / 6) % 2 == 1) ? 2 : 1;
         n_checks++; if (if1.rom_sel !== 3'(e)) $display("FAIL run_sel f=%0d: got %0d expected %0d", f, if1.rom_sel, e); else n_pass++;
         rand_points(8);
      end
      g_pos = 250;
      strobe(50, 280);
      n_checks++; if (if1.rom_sel !== 3'd1) $display("FAIL run_midframe_pos: got %0d expected 1", if1.rom_sel); else n_pass++;
      strobe(0, 0);
      n_checks++; if (if1.rom_sel !== 3'd0) $display("FAIL run_airborne: got %0d expected 0", if1.rom_sel); else n_pass++;
      rand_points(8);
   endtask

   task automatic test_sit();
      int e;
      rom_mode = 1; en_mode = 0; g_gs = 1; g_beh = 1'b0; g_pos = 298;
      do_reset();
      for (int f = 1; f <= 8; f++) begin
         strobe(0, 0);
         strobe(50, 280);
         e = (((f - 1) / 6) % 2 == 1) ? 4 : 3;
         n_checks++; if (if1.rom_sel !== 3'(e)) $display("FAIL sit_sel f=%0d: got %0d expected %0d", f, if1.rom_sel, e); else n_pass++;
         rand_points(8);
      end
      strobe(21, 268);
      n_checks++; if (if1.rom_addr !== 12'd0) $display("FAIL sit_addr_first: got %0d expected 0", if1.rom_addr); else n_pass++;
      strobe(79, 297);
      n_checks++; if (if1.rom_addr !== 12'd1769) $display("FAIL sit_addr_last: got %0d expected 1769", if1.rom_addr); else n_pass++;
      strobe(20, 268);
      n_checks++; if (if1.rom_addr !== 12'd0) $display("FAIL sit_addr_left: got %0d expected 0", if1.rom_addr); else n_pass++;
      strobe(79, 298);
   endtask

   task automatic test_end_blink();
      logic [11:0] e;
      bit hidden;
      rom_mode = 1; en_mode = 1; g_gs = 1; g_beh = 1'b1; g_pos = 298;
      do_reset();
      repeat (2) begin strobe(0, 0); rand_points(4); end
      g_gs = 2;
      for (int f = 0; f < 36; f++) begin
         strobe(0, 0);
         strobe(50, 280);
         n_checks++; if (if1.rom_sel !== 3'd5) $display("FAIL end_sel f=%0d: got %0d expected 5", f, if1.rom_sel); else n_pass++;
         strobe(600, 600); strobe(600, 600);
         hidden = (f >= 1 && f <= 8) || (f >= 17 && f <= 24);
         e = hidden ? BG : 12'h319;
         n_checks++; if (out1() !== e) $display("FAIL blink f=%0d: got %h expected %h", f, out1(), e); else n_pass++;
         rand_points(4);
      end
   endtask

   task automatic test_clip();
      int hl[3] = '{36, 50, 79};
      int vl[6] = '{0, 10, 19, 20, 1000, 1023};
      rom_mode = 1; en_mode = 2; g_gs = 0; g_beh = 1'b1; g_pos = 20;
      do_reset();
      strobe(0, 0);
      strobe(36, 0);
      n_checks++; if (if1.rom_addr !== 12'd1276) $display("FAIL clip_top_addr: got %0d expected 1276", if1.rom_addr); else n_pass++;
      strobe(79, 19);
      n_checks++; if (if1.rom_addr !== 12'd2155) $display("FAIL clip_last_addr: got %0d expected 2155", if1.rom_addr); else n_pass++;
      strobe(50, 1010);
      n_checks++; if (if1.rom_addr !== 12'd0) $display("FAIL clip_nowrap: got %0d expected 0", if1.rom_addr); else n_pass++;
      foreach (vl[j]) foreach (hl[i]) strobe(hl[i], vl[j]);
   endtask

   task automatic test_random();
      int pl[3] = '{298, 250, 20};
      rom_mode = 1; en_mode = 2;
      g_gs = 1; g_beh = 1'b1; g_pos = 298;
      do_reset();
      for (int f = 0; f < 12; f++) begin
         g_gs  = int'($urandom_range(0, 3));
         g_beh = 1'($urandom);
         g_pos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : pl[$urandom_range(0, 2)];
         strobe(0, 0);
         rand_points(8);
         g_gs = int'($urandom_range(0, 3)); g_beh = 1'($urandom); g_pos = int'($urandom_range(0, 1023));
         rand_points(8);
         if (f == 6) begin
            do_reset();
            n_checks++; if (out1() !== BG) $display("FAIL midrst_out1: got %h expected %h", out1(), BG); else n_pass++;
            n_checks++; if (out2() !== BG) $display("FAIL midrst_out2: got %h expected %h", out2(), BG); else n_pass++;
            n_checks++; if (if2.rom_sel !== 3'd0) $display("FAIL midrst_sel: got %0d expected 0", if2.rom_sel); else n_pass++;
            rand_points(10);
         end
      end
   endtask

   initial begin
      rst = 1'b1; pix_en = 1'b0; h_cnt = '0; v_cnt = '0; pos = '0; beh = 1'b0; gs = '0;
      test_reset();
      test_run_anim();
      test_sit();
      test_end_blink();
      test_clip();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end
endmodule

// File: doc/dino_sprite_engine.md
# dino_sprite_engine

Parametrised dino sprite renderer: latches game inputs once per video frame, selects one of six poses (stand, run A/B, sit A/B, dead), generates sprite-ROM addresses for the current scan position, and returns a colour-keyed 12-bit pixel aligned to ROM latency. It sits between the VGA timing counters and the per-layer pixel mux, replacing free-running clock-divider animation with frame-counted animation and death blink.

## Interface
- SPRITE_X, 80, right edge (exclusive) of sprite box in pixels
- GROUND, 298, pos value meaning "on ground"
- STAND_W / STAND_H, 44 / 49, stand/run/dead sprite size
- SIT_W / SIT_H, 59 / 30, sit sprite size
- ADDR_W, 12, ROM address width
- ROM_LATENCY, 1, ROM read latency in pix_en strobes (1..3)
- ANIM_FRAMES, 6, frames per animation phase
- BLINK_FRAMES, 32, frames of death blink
- KEY_COLOR, 12'hFFF, ROM colour treated as transparent
- BG_COLOR, 12'hFFF, colour output outside sprite / transparent
- clk  in  1  pixel-domain clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe; all state advances only when 1 (except rst)
- h_cnt, v_cnt  in  10 each  scan position
- pos  in  10  sprite bottom edge (exclusive), y
- dino_behavior  in  1  1 = stand, 0 = sit
- game_state  in  2  0 INIT, 1 START, 2 END, 3 RESET
- rom_addr  out  ADDR_W  pixel offset within selected sprite
- rom_sel  out  3  pose: 0 STAND, 1 RUN_A, 2 RUN_B, 3 SIT_A, 4 SIT_B, 5 DEAD
- rom_data  in  12  ROM pixel, valid ROM_LATENCY strobes after rom_addr/rom_sel
- vgaRed, vgaGreen, vgaBlue  out  4 each  rendered pixel

## Operation
- Frame start = pix_en && h_cnt==0 && v_cnt==0. On it latch pos_l, beh_l, state_l; inputs between frame starts ignored.
- Animation: at frame start with latched state START, anim_cnt increments; at ANIM_FRAMES-1 wraps to 0 and phase toggles. Non-START: anim_cnt=0, phase=0.
- Blink: at frame start, if new state_l==END and previous !=END, blink_cnt=BLINK_FRAMES; else if END and blink_cnt>0, decrement; if not END, blink_cnt=0. Sprite hidden while blink_cnt!=0 and blink_cnt[3]==1.
- Pose (from latched values): END -> DEAD; START & stand & pos_l==GROUND -> RUN_A/RUN_B by phase; START & stand & airborne -> STAND; START & sit -> SIT_A/SIT_B by phase; INIT/RESET -> STAND if stand else SIT_A.
- Size W,H = SIT_W,SIT_H for poses 3,4; else STAND_W,STAND_H.
- Box: SPRITE_X-W <= h_cnt < SPRITE_X and pos_l-H <= v_cnt < pos_l, compared in 11-bit signed so pos_l<H clips at top, never wraps.
- In box: rom_addr = (v_cnt-(pos_l-H))*W + (h_cnt-(SPRITE_X-W)); outside: rom_addr=0, in_box=0.
- Output: in_box_d && visible_d && rom_data!=KEY_COLOR -> rom_data; else BG_COLOR.

## Timing
- Stage 0 (strobe k): register rom_addr, rom_sel, in_box, visible.
- ROM: data for strobe k valid at strobe k+ROM_LATENCY; in_box/visible delayed by matching ROM_LATENCY-deep shift register (advances on pix_en).
- Output register samples at strobe k+ROM_LATENCY+1; vga pins change only then. Total latency ROM_LATENCY+1 strobes.
- pix_en=0: all registers hold, including outputs.
- Frame latch happens on the frame-start strobe; that strobe's own pixel already uses new values.
- Reset: rom_addr=0, rom_sel=0, vga outputs=BG_COLOR, pipeline valid=0, pos_l=GROUND, beh_l=1, state_l=INIT, anim_cnt=0, phase=0, blink_cnt=0. Reset mid-frame: BG_COLOR until in-flight pipeline refilled; render resumes with defaults without waiting for frame start.
- Simultaneous rst and frame start: rst wins.

## Test plan
- Reset, pos=298, INIT, stand, scan full frame, ROM returns 12'h000 -> black exactly at h 36..79, v 249..297, BG elsewhere; rom_sel=0.
- START, stand, pos=298, ANIM_FRAMES=6 -> rom_sel 1 for frames 1..6, 2 for 7..12, 1 for 13..; pos changed mid-frame to 250 -> no effect until next frame start.
- START, sit -> rom_sel 3/4 alternating, box h 21..79, v 268..297; addr at (h=21,v=268)=0, at (79,297)=1769.
- Transition to END -> rom_sel=5, sprite hidden frames with blink_cnt[3]=1 (counts 31..24, 15..8), visible after 32 frames.
- ROM returns KEY_COLOR at some addresses -> BG_COLOR there; ROM_LATENCY=2 with pix_en every other clk -> output aligned, latency 3 strobes.
- pos=20 (top above screen) -> rows 0..19 drawn, no wrap artefacts near v=1000+; rst asserted mid-frame -> outputs BG next clk.
